// File: rtl/bus_demux_stream.sv
// Registered 1-to-2 stream demultiplexer: each input word is routed to output A or B by in_sel.
// Latency: 1 cycle from input accept to out_x_valid; full throughput of 1 word/cycle per output.
// Backpressure: in_ready follows the selected slot only, so a stalled output never blocks the other.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_data/in_sel/in_valid   producer word, route select (0 -> A, 1 -> B), valid
//   in_ready                  combinational: selected slot can load this cycle
//   out_a_data/valid/ready    consumer A stream (registered data/valid)
//   out_b_data/valid/ready    consumer B stream (registered data/valid)
//   cnt_a, cnt_b              saturating count of completed transfers per output
module bus_demux_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic canload_a;
  logic canload_b;
  logic load_a;
  logic load_b;
  logic xfer_a;
  logic xfer_b;

  // A slot can take a new word when empty, or when its current word leaves
  // this same cycle (drain and load together keep the slot full).
  assign canload_a = !out_a_valid || out_a_ready;
  assign canload_b = !out_b_valid || out_b_ready;

  // Depends on in_sel even with in_valid low, so the producer can look ahead.
  assign in_ready = in_sel ? canload_b : canload_a;

  assign load_a = in_valid && in_ready && !in_sel;
  assign load_b = in_valid && in_ready &&  in_sel;

  assign xfer_a = out_a_valid && out_a_ready;
  assign xfer_b = out_b_valid && out_b_ready;

  // Output A slot
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_valid <= 1'b0;
      out_a_data  <= '0;
    end else if (load_a) begin
      out_a_valid <= 1'b1;
      out_a_data  <= in_data;
    end else if (xfer_a) begin
      // Drain without refill: data keeps its last value.
      out_a_valid <= 1'b0;
    end
  end

  // Output B slot
  always_ff @(posedge clk) begin
    if (rst) begin
      out_b_valid <= 1'b0;
      out_b_data  <= '0;
    end else if (load_b) begin
      out_b_valid <= 1'b1;
      out_b_data  <= in_data;
    end else if (xfer_b) begin
      out_b_valid <= 1'b0;
    end
  end

  // Debug transfer counters, held at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (xfer_a && (cnt_a != {CNT_W{1'b1}})) begin
        cnt_a <= cnt_a + 1'b1;
      end
      if (xfer_b && (cnt_b != {CNT_W{1'b1}})) begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end

endmodule
